udp_rx_cmd: RTL
===============

// Module: udp_rx_cmd
// PURPOSE
//   Receive-side command decoder for the UDP loopback path. Consumes the
//   32-bit payload stream from the UDP receiver and validates 2-word command
//   frames. It executes each valid frame once: LED set/toggle, or a one-cycle
//   UDP transmit request. It is the host-driven counterpart of the local
//   touch-key control, and sits between udp_rx and the LED / UDP-TX start logic.
// PARAMETERS
//   LED_W      2        number of LED outputs (1..16)
//   MAGIC      8'hA5    required value of word0[31:24]
//   TIMEOUT    1250000  max clk cycles from first word to rec_pkt_done (10 ms @125 MHz)
//   LED_INIT   all ones reset value of led (LED_W bits)
// PORTS
//   clk           in   1      system clock
//   rst           in   1      synchronous reset, active-high
//   rec_en        in   1      rec_data valid this cycle (one word per pulse)
//   rec_data      in   32     received payload word, first byte in [31:24]
//   rec_pkt_done  in   1      1-cycle pulse: UDP packet fully received
//   rec_byte_num  in   16     payload byte count; valid when rec_pkt_done=1
//   led           out  LED_W  LED drive, registered
//   tx_start_en   out  1      1-cycle pulse: request one UDP transmission
//   cmd_valid     out  1      1-cycle pulse: a frame was accepted and executed
//   cmd_op        out  8      opcode of the last accepted frame; held until next accept
//   cmd_err       out  1      1-cycle pulse: a frame was rejected
//   err_cnt       out  16     count of rejected frames, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: state=IDLE, led=LED_INIT, cmd_op=0, err_cnt=0, all pulses 0, timer=0.
//   Frame format: word0={MAGIC,op[7:0],arg[15:0]}, word1=~word0, rec_byte_num==8.
//   Opcodes:
//     01 = led<=arg[LED_W-1:0]
//     02 = led<=led^arg[LED_W-1:0]
//     03 = tx_start_en pulse
//     other = reject
//   FSM:
//     IDLE: rec_en -> latch w0, timer=0, go HDR
//     HDR:  rec_en -> latch w1, go CHK
//     CHK:  rec_en -> go DROP (too many words)
//     DROP: absorbs further words
//     In any state, rec_pkt_done -> evaluate the frame, go IDLE.
//   Evaluation at rec_pkt_done is accepted only if all hold:
//     state==CHK, w0[31:24]==MAGIC, w1==~w0, rec_byte_num==8, op is known.
//     Otherwise the frame is rejected.
//   Simultaneous rec_en and rec_pkt_done: the word is consumed first (state
//     advances), then the frame is evaluated in the same cycle.
//   rec_pkt_done in IDLE with no words: reject.
//   Timer counts in HDR/CHK/DROP. At TIMEOUT-1 with no done: reject, go IDLE.
//     The packet tail is then treated as a new frame.
//   Output latency: led, cmd_op, and the pulses (tx_start_en, cmd_valid or
//     cmd_err) all update on the clock edge that samples rec_pkt_done or the
//     timeout. They are visible 1 cycle later.
//   Exactly one of cmd_valid or cmd_err pulses per evaluated frame.
//   On accept, tx_start_en pulses only when op==03.
//   Reject: cmd_err=1, err_cnt+1 (saturating). led and cmd_op are unchanged.
//   rst asserted mid-frame: the frame is discarded, with no pulse and no err_cnt
//     change. The FSM restarts in IDLE.
// TESTING
//   1) words A5010003,5AFEFFFC, done, num=8 -> led=2'b11, cmd_valid 1 cycle,
//      cmd_op=01, err_cnt=0.
//   2) led=2'b11, then frame A5020001 / ~word0 -> led=2'b10. Then frame
//      A5030000 / 5AFCFFFF -> tx_start_en 1 cycle, led unchanged.
//   3) word1 corrupted (5AFEFFFD) -> cmd_err 1 cycle, err_cnt=1, led unchanged,
//      no cmd_valid.
//   4) 3-word packet or num=12 -> cmd_err, FSM in IDLE. The following valid
//      frame is accepted normally.
//   5) word1 sent in the same cycle as rec_pkt_done -> accepted. A bare
//      rec_pkt_done in IDLE -> cmd_err.
//   6) TIMEOUT=16: one word then silence -> cmd_err at cycle 16. rst pulsed
//      between word0 and word1 -> no pulses, err_cnt unchanged, led=LED_INIT.

Source files
------------

// File: rtl/udp_rx_cmd.sv
// udp_rx_cmd: receive-side command decoder for the UDP loopback path.
//
// Consumes the 32-bit payload words from the UDP receiver and validates 2-word
// command frames: word0 = {MAGIC, op, arg}, word1 = ~word0, 8 payload bytes.
// Each frame is evaluated once, when rec_pkt_done_i arrives or the frame timer
// expires. An accepted frame executes its command. A rejected frame bumps
// err_cnt_o.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous reset, active-high
//   rec_en_i         rec_data_i valid this cycle (one word per pulse)
//   rec_data_i       received payload word, first byte in [31:24]
//   rec_pkt_done_i   1-cycle pulse: UDP packet fully received
//   rec_byte_num_i   payload byte count, valid with rec_pkt_done_i
//   led_o            LED drive (registered)
//   tx_start_en_o    1-cycle pulse: request one UDP transmission
//   cmd_valid_o      1-cycle pulse: frame accepted and executed
//   cmd_op_o         opcode of the last accepted frame
//   cmd_err_o        1-cycle pulse: frame rejected
//   err_cnt_o        saturating count of rejected frames
module udp_rx_cmd #(
    parameter int unsigned       LED_W    = 2,
    parameter logic [7:0]        MAGIC    = 8'hA5,
    parameter int unsigned       TIMEOUT  = 1250000,
    parameter logic [LED_W-1:0]  LED_INIT = {LED_W{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rec_en_i,
    input  logic [31:0]      rec_data_i,
    input  logic             rec_pkt_done_i,
    input  logic [15:0]      rec_byte_num_i,
    output logic [LED_W-1:0] led_o,
    output logic             tx_start_en_o,
    output logic             cmd_valid_o,
    output logic [7:0]       cmd_op_o,
    output logic             cmd_err_o,
    output logic [15:0]      err_cnt_o
);

    localparam int unsigned        TimerW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [7:0]         OpSet     = 8'h01;
    localparam logic [7:0]         OpToggle  = 8'h02;
    localparam logic [7:0]         OpTx      = 8'h03;

    typedef enum logic [1:0] {StIdle, StHdr, StChk, StDrop} state_e;

    state_e             state_q, state_d;
    state_e             state_w;  // state after consuming this cycle's word
    logic [31:0]        w0_q, w0_d;
    logic [31:0]        w1_q, w1_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [7:0]         op_q, op_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic               tx_q, tx_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [7:0]         frame_op;
    logic [15:0]        frame_arg;
    logic               op_known;
    logic               frame_ok;
    logic               timeout_hit;

    always_comb begin
        state_w     = state_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        state_d     = state_q;
        timer_d     = timer_q;
        led_d       = led_q;
        op_d        = op_q;
        err_cnt_d   = err_cnt_q;
        tx_d        = 1'b0;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        // Consume the word first so a word arriving with rec_pkt_done_i
        // is part of the frame being evaluated.
        if (rec_en_i) begin
            unique case (state_q)
                StIdle: begin
                    w0_d    = rec_data_i;
                    state_w = StHdr;
                end
                StHdr: begin
                    w1_d    = rec_data_i;
                    state_w = StChk;
                end
                StChk:   state_w = StDrop;
                StDrop:  state_w = StDrop;
                default: state_w = StDrop;
            endcase
        end

        frame_op  = w0_d[23:16];
        frame_arg = w0_d[15:0];
        op_known  = (frame_op == OpSet) || (frame_op == OpToggle) || (frame_op == OpTx);
        frame_ok  = (state_w == StChk) && (w0_d[31:24] == MAGIC) && (w1_d == ~w0_d) &&
                    (rec_byte_num_i == 16'd8) && op_known;

        timeout_hit = (state_q != StIdle) && (timer_q == TimerLast) && !rec_pkt_done_i;

        state_d = state_w;
        // The timer restarts at 0 on the word that opens a frame.
        timer_d = (state_q == StIdle) ? '0 : timer_q + TimerW'(1);

        if (rec_pkt_done_i) begin
            state_d = StIdle;
            timer_d = '0;
            if (frame_ok) begin
                valid_d = 1'b1;
                op_d    = frame_op;
                unique case (frame_op)
                    OpSet:    led_d = frame_arg[LED_W-1:0];
                    OpToggle: led_d = led_q ^ frame_arg[LED_W-1:0];
                    OpTx:     tx_d  = 1'b1;
                    default:  ;
                endcase
            end else begin
                err_d     = 1'b1;
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            end
        end else if (timeout_hit) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            timer_d   = '0;
            // A word arriving on the expiry cycle opens the next frame.
            if (rec_en_i) begin
                w0_d    = rec_data_i;
                state_d = StHdr;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            w0_q      <= '0;
            w1_q      <= '0;
            timer_q   <= '0;
            led_q     <= LED_INIT;
            op_q      <= '0;
            err_cnt_q <= '0;
            tx_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            timer_q   <= timer_d;
            led_q     <= led_d;
            op_q      <= op_d;
            err_cnt_q <= err_cnt_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign led_o         = led_q;
    assign tx_start_en_o = tx_q;
    assign cmd_valid_o   = valid_q;
    assign cmd_op_o      = op_q;
    assign cmd_err_o     = err_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
